// File: rtl/exc_pkg.sv
// Shared definitions for the exception request controller: ExcCodes,
// CP0 status bit positions and the status shift-stack frame width.
package exc_pkg;

    localparam int unsigned FRAME_W = 5;

    localparam int unsigned ST_IE     = 0;
    localparam int unsigned ST_SYS    = 1;
    localparam int unsigned ST_BRK    = 2;
    localparam int unsigned ST_TEQ    = 3;
    localparam int unsigned ST_IM_LSB = 8;

    typedef enum logic [FRAME_W-1:0] {
        EXC_INT     = 5'b00000,
        EXC_SYSCALL = 5'b01000,
        EXC_BREAK   = 5'b01001,
        EXC_TEQ     = 5'b01101
    } exc_code_t;

endpackage

// File: rtl/irq_sync.sv
// Per-line two-flop synchronizer followed by a set/clear pending latch.
// Clear has priority over set so that a still-high line re-arms one edge later.
module irq_sync #(
    parameter int unsigned IRQ_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IRQ_W-1:0] irq,
    input  logic [IRQ_W-1:0] clr,
    output logic [IRQ_W-1:0] pending
);

    logic [IRQ_W-1:0] meta;
    logic [IRQ_W-1:0] sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta    <= '0;
            sync    <= '0;
            pending <= '0;
        end else begin
            meta    <= irq;
            sync    <= meta;
            pending <= (pending | sync) & ~clr;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception request controller feeding CP0: trap/interrupt qualification,
// eret filtering and nesting-depth tracking. Interrupt path built only with EXC_IRQ_EN.
module exc_ctrl
    import exc_pkg::*;
#(
    parameter int unsigned IRQ_W     = 4,
    parameter int unsigned MAX_DEPTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 syscall,
    input  logic                 brk,
    input  logic                 teq,
    input  logic                 teq_eq,
    input  logic                 eret_in,
    input  logic [31:0]          pc,
    input  logic [31:0]          status,
    input  logic [IRQ_W-1:0]     irq,
    output logic                 exception,
    output logic [FRAME_W-1:0]   cause,
    output logic [31:0]          epc,
    output logic                 eret_out,
    output logic [2:0]           depth,
    output logic                 stack_err,
    output logic [IRQ_W-1:0]     irq_pending
);

    localparam logic [2:0] DEPTH_MAX = 3'(MAX_DEPTH);

    logic             sys_v;
    logic             brk_v;
    logic             teq_v;
    logic             int_v;
    logic             req;
    logic             at_max;
    logic             accept;
    exc_code_t        code;
    logic [IRQ_W-1:0] eligible;
    logic [IRQ_W-1:0] int_sel;
    logic [IRQ_W-1:0] irq_clr;

    assign sys_v  = syscall & status[ST_IE] & status[ST_SYS];
    assign brk_v  = brk & status[ST_IE] & status[ST_BRK];
    assign teq_v  = teq & teq_eq & status[ST_IE] & status[ST_TEQ];
    assign int_v  = (|eligible) & status[ST_IE];
    assign at_max = (depth == DEPTH_MAX);

    always_comb begin
        req  = 1'b1;
        code = EXC_INT;
        if (sys_v) begin
            code = EXC_SYSCALL;
        end else if (brk_v) begin
            code = EXC_BREAK;
        end else if (teq_v) begin
            code = EXC_TEQ;
        end else begin
            req = int_v;
        end
    end

    // eret and a full stack both veto the request; reset forces everything quiet
    assign accept    = ~rst & req & ~eret_in & ~at_max;
    assign exception = accept;
    assign cause     = accept ? code : EXC_INT;
    assign epc       = rst ? '0 : pc;
    assign eret_out  = ~rst & eret_in & (depth != '0);

    // isolate the lowest eligible line
    assign int_sel = eligible & (~eligible + IRQ_W'(1));
    assign irq_clr = (accept && code == EXC_INT) ? int_sel : '0;

`ifdef EXC_IRQ_EN
    irq_sync #(
        .IRQ_W(IRQ_W)
    ) u_irq_sync (
        .clk    (clk),
        .rst    (rst),
        .irq    (irq),
        .clr    (irq_clr),
        .pending(irq_pending)
    );

    assign eligible = irq_pending & status[ST_IM_LSB +: IRQ_W];

    logic unused_status;
    assign unused_status = ^{status[31:ST_IM_LSB+IRQ_W], status[ST_IM_LSB-1:ST_TEQ+1]};
`else
    assign irq_pending = '0;
    assign eligible    = '0;

    logic unused_inputs;
    assign unused_inputs = ^{irq, irq_clr, status[31:ST_TEQ+1]};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            depth     <= '0;
            stack_err <= 1'b0;
        end else begin
            if (accept) begin
                depth <= depth + 3'd1;
            end else if (eret_out) begin
                depth <= depth - 3'd1;
            end
            if ((req & ~eret_in & at_max) | (eret_in & (depth == '0))) begin
                stack_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed vector table, interrupt and reset
// sequences, then randomized stimulus against a behavioural model.
module tb_exc_ctrl;

    localparam int IRQ_W     = 4;
    localparam int MAX_DEPTH = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             syscall, brk, teq, teq_eq, eret_in;
    logic [31:0]      pc, status;
    logic [IRQ_W-1:0] irq;
    logic             exception, eret_out, stack_err;
    logic [4:0]       cause;
    logic [31:0]      epc;
    logic [2:0]       depth;
    logic [IRQ_W-1:0] irq_pending;

    always #5 clk = ~clk;

    exc_ctrl #(
        .IRQ_W    (IRQ_W),
        .MAX_DEPTH(MAX_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .syscall    (syscall),
        .brk        (brk),
        .teq        (teq),
        .teq_eq     (teq_eq),
        .eret_in    (eret_in),
        .pc         (pc),
        .status     (status),
        .irq        (irq),
        .exception  (exception),
        .cause      (cause),
        .epc        (epc),
        .eret_out   (eret_out),
        .depth      (depth),
        .stack_err  (stack_err),
        .irq_pending(irq_pending)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model state: nesting count, sticky error, pending set and
    // the irq samples of the last two edges (synchronizer latency).
    int               m_depth = 0;
    bit               m_err   = 0;
    bit [IRQ_W-1:0]   m_pend  = '0;
    bit [IRQ_W-1:0]   m_hist[$] = '{4'b0, 4'b0};

    typedef struct {
        bit          r, sc, bk, tq, tqe, er;
        logic [31:0] st, p;
        bit          e_exc;
        logic [4:0]  e_cause;
        bit          e_ero;
        int          e_depth;
        bit          e_err;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle, compare combinational outputs mid-cycle against the model,
    // advance the model over the edge and compare the registered outputs.
    task automatic apply(input bit r, sc, bk, tq, tqe, er,
                         input logic [31:0] st, p, input logic [IRQ_W-1:0] iq,
                         output bit exc_s, output logic [4:0] cause_s, output bit ero_s);
        bit [4:0]       code;
        bit             req, fire, ero;
        int             sel;
        bit [IRQ_W-1:0] elig, delayed;
        rst = r; syscall = sc; brk = bk; teq = tq; teq_eq = tqe; eret_in = er;
        status = st; pc = p; irq = iq;
        @(negedge clk);
        req = 0; code = 5'd0; sel = -1; elig = '0;
`ifdef EXC_IRQ_EN
        elig = m_pend & st[8 +: IRQ_W];
`endif
        if (sc && st[0] && st[1]) begin
            req = 1; code = 5'd8;
        end else if (bk && st[0] && st[2]) begin
            req = 1; code = 5'd9;
        end else if (tq && tqe && st[0] && st[3]) begin
            req = 1; code = 5'd13;
        end else if (st[0] && elig != 0) begin
            req = 1; code = 5'd0;
            for (int k = IRQ_W - 1; k >= 0; k--) if (elig[k]) sel = k;
        end
        fire = !r && req && !er && (m_depth < MAX_DEPTH);
        ero  = !r && er && (m_depth > 0);
        exc_s = exception; cause_s = cause; ero_s = eret_out;
        chk("exception", exception, fire);
        chk("cause", cause, fire ? code : 5'd0);
        chk("eret_out", eret_out, ero);
        chk("epc", epc, r ? 32'd0 : p);
        @(posedge clk);
        delayed = m_hist.pop_front();
        m_hist.push_back(iq);
        if (r) begin
            m_depth = 0; m_err = 0; m_pend = '0;
            m_hist = '{4'b0, 4'b0};
        end else begin
            if ((req && !er && m_depth == MAX_DEPTH) || (er && m_depth == 0)) m_err = 1;
            if (fire) m_depth++;
            if (ero) m_depth--;
`ifdef EXC_IRQ_EN
            m_pend = m_pend | delayed;
            if (fire && sel >= 0) m_pend[sel] = 1'b0;
`endif
        end
        #1;
        chk("depth", depth, m_depth);
        chk("stack_err", stack_err, m_err);
        chk("irq_pending", irq_pending, m_pend);
    endtask

    function automatic void add(input bit r, sc, bk, tq, tqe, er, input logic [31:0] st, p,
                                input bit e_exc, input logic [4:0] e_cause, input bit e_ero,
                                input int e_depth, input bit e_err);
        vec_t v;
        v.r = r; v.sc = sc; v.bk = bk; v.tq = tq; v.tqe = tqe; v.er = er;
        v.st = st; v.p = p; v.e_exc = e_exc; v.e_cause = e_cause; v.e_ero = e_ero;
        v.e_depth = e_depth; v.e_err = e_err;
        tbl.push_back(v);
    endfunction

    initial begin
        bit         e;
        bit         o;
        logic [4:0] c;
        bit         r, sc, bk, tq, tqe, er;
        logic [31:0] st, p;
        logic [IRQ_W-1:0] iq;

        //  r sc bk tq tqe er  status   pc            exc cause  ero dep err
        add(1, 0, 0, 0, 0, 0, 32'h0,   32'h0,         0, 5'h00, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 32'h3,   32'h00400100,  1, 5'h08, 0, 1, 0);
        add(0, 0, 0, 1, 0, 0, 32'hF,   32'h00400104,  0, 5'h00, 0, 1, 0);
        add(0, 0, 0, 1, 1, 0, 32'hF,   32'h00400108,  1, 5'h0D, 0, 2, 0);
        add(0, 0, 0, 1, 1, 0, 32'h7,   32'h0040010C,  0, 5'h00, 0, 2, 0);
        add(0, 0, 1, 0, 0, 0, 32'h5,   32'h00400110,  1, 5'h09, 0, 3, 0);
        add(0, 1, 0, 0, 0, 0, 32'hF,   32'h00400114,  0, 5'h00, 0, 3, 1);
        add(0, 0, 0, 0, 0, 1, 32'h0,   32'h00400118,  0, 5'h00, 1, 2, 1);
        add(0, 0, 0, 0, 0, 1, 32'h0,   32'h0040011C,  0, 5'h00, 1, 1, 1);
        add(0, 0, 0, 0, 0, 1, 32'h0,   32'h00400120,  0, 5'h00, 1, 0, 1);
        add(0, 0, 0, 0, 0, 1, 32'h0,   32'h00400124,  0, 5'h00, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 32'h0,   32'h0,         0, 5'h00, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 32'h3,   32'h00400200,  0, 5'h00, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 32'h0,   32'h0,         0, 5'h00, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 32'h3,   32'h00400300,  1, 5'h08, 0, 1, 0);
        add(0, 1, 0, 0, 0, 1, 32'h3,   32'h00400304,  0, 5'h00, 1, 0, 0);
        add(0, 1, 1, 0, 0, 0, 32'h7,   32'h00400308,  1, 5'h08, 0, 1, 0);
        add(0, 1, 1, 0, 0, 0, 32'h5,   32'h0040030C,  1, 5'h09, 0, 2, 0);
        add(0, 1, 0, 0, 0, 0, 32'hE,   32'h00400310,  0, 5'h00, 0, 2, 0);
        add(1, 1, 0, 0, 0, 0, 32'h3,   32'h00400314,  0, 5'h00, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].r, tbl[i].sc, tbl[i].bk, tbl[i].tq, tbl[i].tqe, tbl[i].er,
                  tbl[i].st, tbl[i].p, '0, e, c, o);
            chk($sformatf("vec%0d_exc", i), e, tbl[i].e_exc);
            chk($sformatf("vec%0d_cause", i), c, tbl[i].e_cause);
            chk($sformatf("vec%0d_eret", i), o, tbl[i].e_ero);
            chk($sformatf("vec%0d_depth", i), depth, tbl[i].e_depth);
            chk($sformatf("vec%0d_err", i), stack_err, tbl[i].e_err);
        end

        // Interrupt latency: lines 0 and 1 raised before edge N.
        apply(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 4'b0000, e, c, o);
        for (int i = 0; i < 4; i++) begin
            apply(0, 0, 0, 0, 0, 0, 32'h301, 32'h00400400 + 32'(i * 4), 4'b0011, e, c, o);
`ifdef EXC_IRQ_EN
            chk($sformatf("irq_lat%0d", i), e, (i == 3) ? 1'b1 : 1'b0);
`else
            chk($sformatf("irq_off%0d", i), e, 1'b0);
`endif
        end
`ifdef EXC_IRQ_EN
        chk("irq_sel_cause", c, 5'd0);
        chk("irq_pend_after", irq_pending, 4'b0010);
`else
        chk("irq_pend_off", irq_pending, 4'b0000);
`endif

        // Reset in the middle of a nested handler with an interrupt pending.
        apply(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 4'b0000, e, c, o);
        apply(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 4'b0100, e, c, o);
        apply(0, 1, 0, 0, 0, 0, 32'h3, 32'h00400500, 4'b0100, e, c, o);
        apply(0, 1, 0, 0, 0, 0, 32'h3, 32'h00400504, 4'b0100, e, c, o);
        chk("pre_rst_depth", depth, 3'd2);
`ifdef EXC_IRQ_EN
        chk("pre_rst_pend", irq_pending, 4'b0100);
`endif
        apply(1, 1, 0, 0, 0, 1, 32'h3, 32'h00400508, 4'b0000, e, c, o);
        chk("rst_exc", e, 1'b0);
        chk("rst_eret", o, 1'b0);
        chk("rst_depth", depth, 3'd0);
        chk("rst_pend", irq_pending, 4'b0000);
        chk("rst_err", stack_err, 1'b0);

        // Randomized traffic against the model.
        iq = '0;
        for (int i = 0; i < 600; i++) begin
            r   = ($urandom_range(0, 39) == 0);
            sc  = ($urandom_range(0, 2) == 0);
            bk  = ($urandom_range(0, 3) == 0);
            tq  = ($urandom_range(0, 3) == 0);
            tqe = $urandom_range(0, 1) != 0;
            er  = ($urandom_range(0, 3) == 0);
            st  = $urandom;
            if ($urandom_range(0, 3) != 0) st[0] = 1'b1;
            p   = $urandom;
            if ($urandom_range(0, 5) == 0) iq = IRQ_W'($urandom);
            apply(r, sc, bk, tq, tqe, er, st, p, iq, e, c, o);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
